// File: rtl/random_key_collector.sv
// random_key_collector: samples an LFSR byte stream every DECIM clocks,
// assembles KEY_BYTES bytes into a key, rejects all-zero keys and hands
// the key off with a valid/ack handshake, zeroizing it afterwards.
// Optional build macro: RANDOM_KEY_WHITEN_EN (whitens each raw sample
// with a rotated copy of the previous raw byte).
// Ports:
//   i_clk, i_reset_n   clock, synchronous active-low reset
//   i_start            request a new key
//   i_rand_data[7:0]   random byte, valid every cycle
//   i_key_ack          consumer accepts o_key
//   o_key[W-1:0]       key, first captured byte in MSBs, 0 outside VALID
//   o_key_valid        o_key holds a non-zero key
//   o_busy             collecting or checking
//   o_reject           one-cycle pulse when an all-zero key is discarded
module random_key_collector #(
   parameter int KEY_BYTES = 32,
   parameter int DECIM     = 8
) (
   input  logic                   i_clk,
   input  logic                   i_reset_n,
   input  logic                   i_start,
   input  logic [7:0]             i_rand_data,
   input  logic                   i_key_ack,
   output logic [KEY_BYTES*8-1:0] o_key,
   output logic                   o_key_valid,
   output logic                   o_busy,
   output logic                   o_reject
);

   localparam int W  = KEY_BYTES * 8;
   localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int BW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
   localparam logic [DW-1:0] DLAST = DW'(DECIM - 1);
   localparam logic [BW-1:0] BLAST = BW'(KEY_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      CHECK,
      VALID
   } state_e;

   state_e          state_q, state_d;
   logic [W-1:0]    acc_q, acc_d;
   logic [W-1:0]    key_q, key_d;
   logic [DW-1:0]   dcnt_q, dcnt_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic [7:0]      sample;
   logic            acc_zero;

`ifdef RANDOM_KEY_WHITEN_EN
   logic [7:0]      prev_q, prev_d;
   assign sample = i_rand_data ^ {prev_q[6:0], prev_q[7]};
`else
   assign sample = i_rand_data;
`endif

   assign acc_zero = (acc_q == '0);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         key_q   <= '0;
         dcnt_q  <= '0;
         bcnt_q  <= '0;
`ifdef RANDOM_KEY_WHITEN_EN
         prev_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         key_q   <= key_d;
         dcnt_q  <= dcnt_d;
         bcnt_q  <= bcnt_d;
`ifdef RANDOM_KEY_WHITEN_EN
         prev_q  <= prev_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      key_d   = key_q;
      dcnt_d  = dcnt_q;
      bcnt_d  = bcnt_q;
`ifdef RANDOM_KEY_WHITEN_EN
      prev_d  = prev_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (i_start) begin
               state_d = COLLECT;
               acc_d   = '0;
               dcnt_d  = '0;
               bcnt_d  = '0;
`ifdef RANDOM_KEY_WHITEN_EN
               prev_d  = '0;
`endif
            end
         end
         COLLECT: begin
            if (dcnt_q == DLAST) begin
               dcnt_d = '0;
               acc_d  = (acc_q << 8) | W'(sample);
`ifdef RANDOM_KEY_WHITEN_EN
               prev_d = i_rand_data;
`endif
               if (bcnt_q == BLAST) begin
                  bcnt_d  = '0;
                  state_d = CHECK;
               end else begin
                  bcnt_d = bcnt_q + BW'(1);
               end
            end else begin
               dcnt_d = dcnt_q + DW'(1);
            end
         end
         CHECK: begin
            if (acc_zero) begin
               // Discard and retry from a clean slate.
               state_d = COLLECT;
               acc_d   = '0;
               dcnt_d  = '0;
               bcnt_d  = '0;
`ifdef RANDOM_KEY_WHITEN_EN
               prev_d  = '0;
`endif
            end else begin
               // Move the key out; the accumulator keeps no copy.
               key_d   = acc_q;
               acc_d   = '0;
               state_d = VALID;
            end
         end
         VALID: begin
            // Ack wins over a simultaneous start.
            if (i_key_ack) begin
               key_d   = '0;
               state_d = IDLE;
            end
         end
      endcase
   end

   assign o_key       = key_q;
   assign o_key_valid = (state_q == VALID);
   assign o_busy      = (state_q == COLLECT) || (state_q == CHECK);
   assign o_reject    = (state_q == CHECK) && acc_zero;

endmodule
